div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU. Sequenced by the execute stage through a start/ready handshake; execute holds its stall request until ready.
- Sits beside the execute stage.
- Returns {remainder, quotient}, which execute writes to HI/LO.

Parameters:
DATA_W, 32, operand width; result width is 2*DATA_W. Only 32 is required to work.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset (RstEnable = 1'b1), sampled on the rising edge of clk
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  in  32  dividend
opdata2_i  in  32  divisor
start_i  in  1  1 = DivStart, 0 = DivStop
annul_i  in  1  cancel the current operation (pipeline flush)
result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO)
ready_o  out  1  1 = DivResultReady, 0 = DivResultNotReady

Behaviour:
- All state and outputs are registered; there is no combinational path from inputs to outputs.
- Reset (rst=1 at an edge, in any state including mid-division): state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend register=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 && annul_i=0 && opdata2_i=0 -> BYZERO.
  - start_i=1 && annul_i=0 && opdata2_i!=0 -> ON, with:
    - cnt=0;
    - latch the sign flags s1=opdata1_i[31], s2=opdata2_i[31] and signed_div_i;
    - in signed mode, negative operands are replaced by their two's complement (magnitudes);
    - dividend register (65 bits) = {32'b0, |op1|, 1'b0};
    - divisor register = |op2|.
  - Otherwise stay in FREE, with ready_o=0 and result_o=0.
- ON, each edge:
  - If annul_i=1 -> FREE; no result is produced.
  - Else if cnt<32, perform one iteration:
    - tmp = {1'b0, dividend[63:32]} - {1'b0, divisor};
    - tmp[32]=1 -> dividend = {dividend[63:0], 1'b0};
    - tmp[32]=0 -> dividend = {tmp[31:0], dividend[31:0], 1'b1};
    - cnt++.
  - Else (cnt==32):
    - q = dividend[31:0];
    - r = dividend[64:33];
    - if signed && (s1^s2), q = -q;
    - if signed && s1, r = -r (the remainder takes the dividend's sign);
    - result_o = {r, q}, ready_o=1, cnt=0 -> END.
- BYZERO, one edge: result_o=0, ready_o=1 -> END. Annul_i=1 here -> FREE with ready_o=0.
- END:
  - While start_i=1, hold: ready_o=1 and result_o stable.
  - When start_i=0 -> FREE, with ready_o=0 and result_o=0 on that edge.
  - annul_i=1 in END -> FREE as well.
- Latency:
  - Start sampled at edge E0.
  - ready_o=1 after edge E0+33 (nonzero divisor).
  - ready_o=1 after edge E0+1 (zero divisor).
- Operands may change after E0; only latched copies are used.
- start_i=1 while in ON or BYZERO is ignored; the operation is not restarted.
- Overflow case 0x80000000 / 0xFFFFFFFF signed wraps: q=0x80000000, r=0. No exception is raised.
- Priority: rst > annul_i > start_i.

Test Plan:
1. Reset, then unsigned 7/2 with start held -> ready_o rises 33 edges after the start edge; result_o=0x00000001_00000003. Deassert start -> next edge ready_o=0, result_o=0.
2. Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2 -> 0x00000001_7FFFFFFC.
3. Divide by zero (0x1234, 0) -> ready_o=1 after 1 edge past start; result_o=0.
4. annul_i=1 at cnt=10 -> FREE, ready_o never asserts. A new start for 100/7 then gives 0x00000002_0000000E after 33 edges.
5. rst=1 at cnt=20 -> next edge ready_o=0, result_o=0, state FREE. A subsequent signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
6. Change opdata1_i/opdata2_i every cycle during ON -> result matches the operands sampled at the start edge.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider serving DIV (signed) and DIVU
//   (unsigned). Execute raises start_i, holds it (and its stall) until
//   ready_o, then drops start_i to release the unit. One quotient bit is
//   produced per clock, so a nonzero-divisor result appears DATA_W+1 edges
//   after the start edge; a zero divisor answers after a single edge with 0.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       1 = request/hold a division, 0 = release the unit
//   annul_i       cancel the current operation (pipeline flush)
//   result_o      {remainder, quotient}  -> {HI, LO}
//   ready_o       result valid while held in END
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t                 state_r,    state_nxt;
  logic [CNT_W-1:0]       cnt_r,      cnt_nxt;
  logic [2*DATA_W:0]      dividend_r, dividend_nxt;
  logic [DATA_W-1:0]      divisor_r,  divisor_nxt;
  logic                   s1_r,       s1_nxt;
  logic                   s2_r,       s2_nxt;
  logic                   sgn_r,      sgn_nxt;
  logic [2*DATA_W-1:0]    result_r,   result_nxt;
  logic                   ready_r,    ready_nxt;

  logic [DATA_W:0]        trial;
  logic [DATA_W-1:0]      quot;
  logic [DATA_W-1:0]      rem;

  // Two's complement negation; wraps for the most negative value, which is
  // what makes MIN / -1 come out as MIN with no exception.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v,
                                               input logic              sgn);
    return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
  endfunction

  // Trial subtraction of the divisor from the upper partial remainder; the
  // extra top bit is the borrow that decides whether the subtraction stands.
  assign trial = {1'b0, dividend_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};

  // After DATA_W iterations the low half holds the quotient and the
  // remainder sits one bit above the upper half because of the initial shift.
  assign quot = dividend_r[DATA_W-1:0];
  assign rem  = dividend_r[2*DATA_W:DATA_W+1];

  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    dividend_nxt = dividend_r;
    divisor_nxt  = divisor_r;
    s1_nxt       = s1_r;
    s2_nxt       = s2_r;
    sgn_nxt      = sgn_r;
    result_nxt   = result_r;
    ready_nxt    = ready_r;

    case (state_r)
      ST_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = ST_BYZERO;
          end else begin
            state_nxt    = ST_ON;
            cnt_nxt      = '0;
            s1_nxt       = opdata1_i[DATA_W-1];
            s2_nxt       = opdata2_i[DATA_W-1];
            sgn_nxt      = signed_div_i;
            dividend_nxt = {{DATA_W{1'b0}}, mag_w(opdata1_i, signed_div_i), 1'b0};
            divisor_nxt  = mag_w(opdata2_i, signed_div_i);
          end
        end
      end

      ST_BYZERO: begin
        if (annul_i) begin
          state_nxt  = ST_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else begin
          state_nxt  = ST_END;
          ready_nxt  = 1'b1;
          result_nxt = '0;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          state_nxt = ST_FREE;
          ready_nxt = 1'b0;
        end else if (cnt_r != CNT_W'(DATA_W)) begin
          if (trial[DATA_W]) begin
            dividend_nxt = {dividend_r[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_nxt = {trial[DATA_W-1:0], dividend_r[DATA_W-1:0], 1'b1};
          end
          cnt_nxt = cnt_r + 1'b1;
        end else begin
          // Quotient is negative when operand signs differ; the remainder
          // follows the dividend's sign.
          result_nxt = {((sgn_r && s1_r) ? neg_w(rem) : rem),
                        ((sgn_r && (s1_r ^ s2_r)) ? neg_w(quot) : quot)};
          ready_nxt  = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = ST_END;
        end
      end

      ST_END: begin
        if (annul_i || !start_i) begin
          state_nxt  = ST_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end

      default: begin
        state_nxt  = ST_FREE;
        ready_nxt  = 1'b0;
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FREE;
      cnt_r      <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      sgn_r      <= 1'b0;
      result_r   <= '0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      dividend_r <= dividend_nxt;
      divisor_r  <= divisor_nxt;
      s1_r       <= s1_nxt;
      s2_r       <= s2_nxt;
      sgn_r      <= sgn_nxt;
      result_r   <= result_nxt;
      ready_r    <= ready_nxt;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (ready_o === 1'b1 && rdy_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got ready=1 with result 0x%016h expected no result", result_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check64("result", result_o, e.res);
        check_int("latency_cycle", cyc, e.due);
      end
    end
    rdy_prev = ready_o;
  end

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res,
                         input int lat, input bit scramble);
    exp_t e;
    bit   seen;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    e.res = res;
    e.due = cyc + 1 + lat;
    exp_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        seen = 1;
        break;
      end
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = $urandom_range(0, 1);
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s_timeout: got no ready within 60 cycles expected ready", name);
      void'(exp_q.pop_front());
    end
    // Start still held: result must stay presented.
    @(negedge clk);
    check64({name, "_hold"}, {result_o[63:1], result_o[0] ^ ~ready_o}, res);
    start_i = 1'b0;
    @(negedge clk);
    check64({name, "_release"}, {63'd0, ready_o}, 64'd0);
    check64({name, "_release_res"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check64("reset_ready", {63'd0, ready_o}, 64'd0);
    check64("reset_result", result_o, 64'd0);
    rst = 1'b0;

    // Basic unsigned and signed cases
    run_div("udiv_7_2",   1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33, 0);
    run_div("sdiv_m7_2",  1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("sdiv_7_m2",  1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    run_div("udiv_big_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33, 0);

    // Divide by zero
    run_div("div_zero",   1'b0, 32'h00001234, 32'd0,        64'd0,                 1,  0);

    // Annul mid-division at cnt=10
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);
    check64("annul_no_ready", {63'd0, ready_o}, 64'd0);
    run_div("udiv_100_7", 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 0);

    // Reset mid-division at cnt=20
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    check64("midrst_ready", {63'd0, ready_o}, 64'd0);
    check64("midrst_result", result_o, 64'd0);
    repeat (40) @(negedge clk);
    check64("midrst_no_ready", {63'd0, ready_o}, 64'd0);
    run_div("sdiv_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);

    // Operands change every cycle while dividing
    run_div("scr_s1000_m7", 1'b1, 32'd1000,   32'hFFFFFFF9, 64'h00000006_FFFFFF72, 33, 1);
    run_div("scr_u_ff_ff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, 1);
    run_div("scr_u_5_9",    1'b0, 32'd5,      32'd9,        64'h00000005_00000000, 33, 1);

    repeat (3) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
